// File: rtl/mhsa_host_ctrl.sv
// -----------------------------------------------------------------------------
// mhsa_host_ctrl
//
// Host-side job sequencer for an attention accelerator. A job command gives an
// input region and an output region inside the accelerator buffer. The block:
//   1. streams input words into the buffer,
//   2. pulses start,
//   3. waits for done,
//   4. reads the output region back and presents it as a valid/ready stream.
// All buffer addresses wrap modulo LENGTH. Lengths above LENGTH are clamped.
//
// Optional feature: define MHSA_HOST_TIMEOUT_EN to enable a WAIT watchdog.
// After TIMEOUT_CYCLES cycles in WAIT without done, err_timeout is set and the
// job finishes without reading results. err_timeout stays set until reset or
// until the next command is accepted. Without the macro, WAIT waits forever
// and err_timeout is tied to 0.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_in_base/cmd_out_base      region bases (AW bits)
//   cmd_in_len/cmd_out_len        region lengths in words (AW+1 bits)
//   in_valid/in_ready/in_data     input word stream
//   out_valid/out_ready/out_data  result word stream
//   start/done                    accelerator kick and completion
//   input_base/output_base        accelerator region bases
//   soc_write_en/soc_addr         accelerator buffer port; read data
//   soc_data_in/soc_data_out        (soc_data_out) arrives one cycle after
//                                   the address
//   busy                          high when not idle
//   job_done                      one-cycle pulse at job end
//   err_timeout                   sticky watchdog flag
// -----------------------------------------------------------------------------
module mhsa_host_ctrl #(
   parameter int  WIDTH          = 64,
   parameter int  LENGTH         = 4096,
   parameter int  TIMEOUT_CYCLES = 1000000,
   localparam int AW             = $clog2(LENGTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [AW-1:0]    cmd_in_base,
   input  logic [AW-1:0]    cmd_out_base,
   input  logic [AW:0]      cmd_in_len,
   input  logic [AW:0]      cmd_out_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             start,
   input  logic             done,
   output logic [AW-1:0]    input_base,
   output logic [AW-1:0]    output_base,
   output logic             soc_write_en,
   output logic [AW-1:0]    soc_addr,
   output logic [WIDTH-1:0] soc_data_in,
   input  logic [WIDTH-1:0] soc_data_out,
   output logic             busy,
   output logic             job_done,
   output logic             err_timeout
);

   localparam logic [AW:0]   LEN_MAX = (AW+1)'(LENGTH);
   localparam logic [AW+1:0] LEN_MOD = (AW+2)'(LENGTH);
   localparam logic [AW:0]   ONE     = (AW+1)'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_KICK    = 3'd2,
      S_WAIT    = 3'd3,
      S_RD_ADDR = 3'd4,
      S_RD_DATA = 3'd5,
      S_HOLD    = 3'd6,
      S_FIN     = 3'd7
   } state_t;

   // Lengths above the buffer depth are clamped to the buffer depth.
   function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
      logic [AW:0] res;
      if (len > LEN_MAX) begin
         res = LEN_MAX;
      end else begin
         res = len;
      end
      return res;
   endfunction

   // (base + off) mod LENGTH. base may exceed LENGTH-1 when LENGTH is not a
   // power of two, so the sum is below 3*LENGTH and two folds suffice.
   function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] base,
                                               input logic [AW:0]   off);
      logic [AW+1:0] sum;
      sum = {2'b00, base} + {1'b0, off};
      sum = (sum >= LEN_MOD) ? (sum - LEN_MOD) : sum;
      sum = (sum >= LEN_MOD) ? (sum - LEN_MOD) : sum;
      return sum[AW-1:0];
   endfunction

   state_t           r_state;
   state_t           w_next;
   logic             r_live;       // low in reset, high from the first edge after release
   logic [AW-1:0]    r_in_base;
   logic [AW-1:0]    r_out_base;
   logic [AW:0]      r_in_len;
   logic [AW:0]      r_out_len;
   logic [AW:0]      r_cnt;
   logic [WIDTH-1:0] r_out_data;

   logic             w_cmd_ready;
   logic             w_in_ready;
   logic             w_we;
   logic [AW-1:0]    w_addr;
   logic [WIDTH-1:0] w_wdata;
   logic             w_start;
   logic             w_out_valid;
   logic             w_job_done;

`ifdef MHSA_HOST_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_wait_cnt;
   logic          r_err_timeout;
   logic          w_timeout;
`endif

   // Next-state and per-state output decode.
   always_comb begin
      w_next      = r_state;
      w_cmd_ready = 1'b0;
      w_in_ready  = 1'b0;
      w_we        = 1'b0;
      w_addr      = '0;
      w_wdata     = '0;
      w_start     = 1'b0;
      w_out_valid = 1'b0;
      w_job_done  = 1'b0;
`ifdef MHSA_HOST_TIMEOUT_EN
      w_timeout   = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            w_cmd_ready = r_live;
            if (cmd_valid && r_live) begin
               if (cmd_in_len == '0) begin
                  w_next = S_KICK;
               end else begin
                  w_next = S_LOAD;
               end
            end else begin
               w_next = S_IDLE;
            end
         end
         S_LOAD: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_we    = 1'b1;
               w_addr  = wrap_addr(r_in_base, r_cnt);
               w_wdata = in_data;
               if (r_cnt == r_in_len - ONE) begin
                  w_next = S_KICK;
               end else begin
                  w_next = S_LOAD;
               end
            end else begin
               w_next = S_LOAD;
            end
         end
         S_KICK: begin
            w_start = 1'b1;
            w_next  = S_WAIT;
         end
         S_WAIT: begin
            if (done) begin
               if (r_out_len == '0) begin
                  w_next = S_FIN;
               end else begin
                  w_next = S_RD_ADDR;
               end
            end
`ifdef MHSA_HOST_TIMEOUT_EN
            else if (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               w_next    = S_FIN;
               w_timeout = 1'b1;
            end
`endif
            else begin
               w_next = S_WAIT;
            end
         end
         S_RD_ADDR: begin
            w_addr = wrap_addr(r_out_base, r_cnt);
            w_next = S_RD_DATA;
         end
         S_RD_DATA: begin
            w_next = S_HOLD;
         end
         S_HOLD: begin
            w_out_valid = 1'b1;
            if (out_ready) begin
               if (r_cnt == r_out_len - ONE) begin
                  w_next = S_FIN;
               end else begin
                  w_next = S_RD_ADDR;
               end
            end else begin
               w_next = S_HOLD;
            end
         end
         S_FIN: begin
            w_job_done = 1'b1;
            w_next     = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Job fields, word counter and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live     <= 1'b0;
         r_in_base  <= '0;
         r_out_base <= '0;
         r_in_len   <= '0;
         r_out_len  <= '0;
         r_cnt      <= '0;
         r_out_data <= '0;
      end else begin
         r_live <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid && w_cmd_ready) begin
                  r_in_base  <= cmd_in_base;
                  r_out_base <= cmd_out_base;
                  r_in_len   <= clamp_len(cmd_in_len);
                  r_out_len  <= clamp_len(cmd_out_len);
                  r_cnt      <= '0;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  r_cnt <= r_cnt + ONE;
               end
            end
            S_WAIT: begin
               if (done) begin
                  r_cnt <= '0;
               end
            end
            S_RD_DATA: begin
               r_out_data <= soc_data_out;
            end
            S_HOLD: begin
               if (out_ready) begin
                  r_cnt <= r_cnt + ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef MHSA_HOST_TIMEOUT_EN
   // WAIT-cycle watchdog and its sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt    <= '0;
         r_err_timeout <= 1'b0;
      end else begin
         if (r_state == S_KICK) begin
            r_wait_cnt <= '0;
         end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
         end
         if (cmd_valid && w_cmd_ready) begin
            r_err_timeout <= 1'b0;
         end else if (w_timeout) begin
            r_err_timeout <= 1'b1;
         end
      end
   end
   assign err_timeout = r_err_timeout;
`else
   assign err_timeout = 1'b0;
`endif

   assign cmd_ready    = w_cmd_ready;
   assign in_ready     = w_in_ready;
   assign soc_write_en = w_we;
   assign soc_addr     = w_addr;
   assign soc_data_in  = w_wdata;
   assign start        = w_start;
   assign out_valid    = w_out_valid;
   assign out_data     = r_out_data;
   assign job_done     = w_job_done;
   assign busy         = (r_state != S_IDLE);
   assign input_base   = r_in_base;
   assign output_base  = r_out_base;

endmodule

// File: tb/tb_mhsa_host_ctrl.sv
module tb_mhsa_host_ctrl;
   localparam int W  = 16;
   localparam int L  = 32;
   localparam int AW = 5;
   localparam int TO = 100;

   logic clk = 1'b0;
   logic rst_n;
   logic cmd_valid, cmd_ready;
   logic [AW-1:0] cmd_in_base, cmd_out_base;
   logic [AW:0] cmd_in_len, cmd_out_len;
   logic in_valid, in_ready;
   logic [W-1:0] in_data;
   logic out_valid, out_ready;
   logic [W-1:0] out_data;
   logic start, done;
   logic [AW-1:0] input_base, output_base;
   logic soc_write_en;
   logic [AW-1:0] soc_addr;
   logic [W-1:0] soc_data_in, soc_data_out;
   logic busy, job_done, err_timeout;

   mhsa_host_ctrl #(.WIDTH(W), .LENGTH(L), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_in_base(cmd_in_base), .cmd_out_base(cmd_out_base),
      .cmd_in_len(cmd_in_len), .cmd_out_len(cmd_out_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .start(start), .done(done),
      .input_base(input_base), .output_base(output_base),
      .soc_write_en(soc_write_en), .soc_addr(soc_addr),
      .soc_data_in(soc_data_in), .soc_data_out(soc_data_out),
      .busy(busy), .job_done(job_done), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Accelerator buffer: unwritten words read as 16'hA000 + address.
   logic [W-1:0] mem [L];
   bit           written [L];
   always @(posedge clk) begin
      if (soc_write_en) begin
         mem[soc_addr]     <= soc_data_in;
         written[soc_addr] <= 1'b1;
      end
      soc_data_out <= written[soc_addr] ? mem[soc_addr] : (16'hA000 + 16'(soc_addr));
   end

   // Reference model state (owned by the stimulus process).
   logic [W-1:0]  exp_mem [L];
   logic [AW-1:0] ew_a [512];
   logic [W-1:0]  ew_d [512];
   logic [W-1:0]  eo_d [512];
   int ew_tail = 0, eo_tail = 0;
   int exp_ib = 0, exp_ob = 0;
   bit to_mode = 1'b0;
   bit accel_en = 1'b1;
   int stall_req = 0;

   // Observations (owned by the compare process).
   int ew_head = 0, eo_head = 0;
   logic [AW-1:0] got_wa [512];
   logic [W-1:0]  got_od [512];
   int n_wr = 0, n_od = 0, n_start = 0, n_done = 0, n_wait = 0;
   logic exp_err = 1'b0;
   logic pv = 1'b0, pr = 1'b0, ps = 1'b0, ph = 1'b0;
   logic [W-1:0] pd = '0;
   logic [AW-1:0] pa = '0;

   // Out-ready driver with a programmable stall count.
   int stall_used = 0;
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (out_valid && stall_used < stall_req) begin
            out_ready = 1'b0;
            stall_used++;
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // Fake accelerator: done pulse three cycles after start.
   initial begin
      done = 1'b0;
      forever begin
         @(negedge clk);
         if (start && accel_en) begin
            repeat (3) @(posedge clk);
            #1 done = 1'b1;
            @(posedge clk);
            #1 done = 1'b0;
         end
      end
   end

   // Compare process: checks the DUT against the model every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_err = 1'b0; pv = 1'b0; pr = 1'b0; ps = 1'b0; ph = 1'b0;
         end else begin
            if (ph) exp_err = 1'b0;
            if (job_done && to_mode) exp_err = 1'b1;
            chk("err_timeout", err_timeout, exp_err);
            if (soc_write_en) begin
               chk("wr_handshake", in_valid & in_ready, 1);
               if (ew_head < ew_tail) begin
                  chk("wr_addr", soc_addr, ew_a[ew_head]);
                  chk("wr_data", soc_data_in, ew_d[ew_head]);
                  ew_head++;
               end else begin
                  chk("unexpected_write", 1, 0);
               end
               got_wa[n_wr] = soc_addr;
               n_wr++;
            end
            if (out_valid) begin
               if (eo_head >= eo_tail) begin
                  chk("unexpected_out", 1, 0);
               end else if (out_ready) begin
                  chk("out_data", out_data, eo_d[eo_head]);
                  eo_head++;
                  got_od[n_od] = out_data;
                  n_od++;
               end
            end
            if (out_valid && pv && !pr) begin
               chk("hold_data", out_data, pd);
               chk("hold_addr", soc_addr, pa);
            end
            if (start) begin
               n_start++;
               chk("start_single", ps, 0);
               chk("input_base", input_base, exp_ib);
               chk("output_base", output_base, exp_ob);
            end
            if (job_done) n_done++;
            if (busy && !start && !job_done && !in_ready && !out_valid) n_wait++;
            if (cmd_ready) chk("idle_not_busy", busy, 0);
            if (in_ready || out_valid || start || job_done) chk("busy_flag", busy, 1);
            pv = out_valid; pr = out_ready; pd = out_data; pa = soc_addr;
            ps = start; ph = cmd_valid & cmd_ready;
         end
      end
   end

   task automatic zero_check();
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_start", start, 0);
      chk("rst_input_base", input_base, 0);
      chk("rst_output_base", output_base, 0);
      chk("rst_soc_write_en", soc_write_en, 0);
      chk("rst_soc_addr", soc_addr, 0);
      chk("rst_soc_data_in", soc_data_in, 0);
      chk("rst_busy", busy, 0);
      chk("rst_job_done", job_done, 0);
      chk("rst_err_timeout", err_timeout, 0);
   endtask

   task automatic expect_job(input int ib, input int il, input int ob, input int ol,
                             input logic [W-1:0] tag, input bit reads);
      int nin, nout, a;
      nin  = (il > L) ? L : il;
      nout = (ol > L) ? L : ol;
      for (int i = 0; i < nin; i++) begin
         a = (ib + i) % L;
         ew_a[ew_tail] = AW'(a);
         ew_d[ew_tail] = tag + W'(i);
         exp_mem[a]    = tag + W'(i);
         ew_tail++;
      end
      if (reads) begin
         for (int k = 0; k < nout; k++) begin
            eo_d[eo_tail] = exp_mem[(ob + k) % L];
            eo_tail++;
         end
      end
   endtask

   task automatic send_cmd(input int ib, input int il, input int ob, input int ol);
      int t;
      cmd_in_base  = AW'(ib);
      cmd_in_len   = (AW+1)'(il);
      cmd_out_base = AW'(ob);
      cmd_out_len  = (AW+1)'(ol);
      cmd_valid    = 1'b1;
      t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("cmd_ready_wait", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic send_words(input int n, input logic [W-1:0] tag);
      int t;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = tag + W'(i);
         t = 0;
         @(negedge clk);
         while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         chk("in_ready_wait", in_ready, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic wait_done(input int d0, input int limit);
      int t;
      t = 0;
      while (n_done == d0 && t < limit) begin
         @(negedge clk);
         t++;
      end
      chk("job_done_wait", n_done - d0, 1);
      @(posedge clk); #1;
   endtask

   task automatic run_job(input int ib, input int il, input int ob, input int ol,
                          input logic [W-1:0] tag, input int stall);
      int s0, d0;
      s0 = n_start;
      d0 = n_done;
      exp_ib = ib;
      exp_ob = ob;
      stall_req = stall_used + stall;
      expect_job(ib, il, ob, ol, tag, 1'b1);
      send_cmd(ib, il, ob, ol);
      send_words((il > L) ? L : il, tag);
      wait_done(d0, 3000);
      chk("start_count", n_start - s0, 1);
      chk("writes_pending", ew_tail - ew_head, 0);
      chk("outs_pending", eo_tail - eo_head, 0);
      chk("busy_after", busy, 0);
      chk("cmd_ready_after", cmd_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int wa0, od0, s0, d0, w0;
      for (int a = 0; a < L; a++) exp_mem[a] = 16'hA000 + 16'(a);
      rst_n = 1'b1;
      cmd_valid = 1'b0; cmd_in_base = '0; cmd_out_base = '0;
      cmd_in_len = '0; cmd_out_len = '0;
      in_valid = 1'b0; in_data = 16'hFFFF;
      #2 rst_n = 1'b0;
      #1 zero_check();
      in_data = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("cmd_ready_after_release", cmd_ready, 1);

      // Basic job: writes 0..3, reads 16,17.
      wa0 = n_wr; od0 = n_od;
      run_job(0, 4, 16, 2, 16'hC100, 0);
      for (int i = 0; i < 4; i++) chk("jobA_wr_addr", got_wa[wa0 + i], i);
      chk("jobA_out0", got_od[od0], 16'hA010);
      chk("jobA_out1", got_od[od0 + 1], 16'hA011);

      // Wrapping addresses plus a 10-cycle output stall.
      wa0 = n_wr; od0 = n_od;
      run_job(30, 4, 31, 2, 16'hB000, 10);
      chk("jobB_wr0", got_wa[wa0], 30);
      chk("jobB_wr1", got_wa[wa0 + 1], 31);
      chk("jobB_wr2", got_wa[wa0 + 2], 0);
      chk("jobB_wr3", got_wa[wa0 + 3], 1);
      chk("jobB_out0", got_od[od0], 16'hB001);
      chk("jobB_out1", got_od[od0 + 1], 16'hB002);
      chk("jobB_stall_used", stall_req - stall_used, 0);

      // Zero-length job: no writes, no outputs.
      wa0 = n_wr; od0 = n_od;
      run_job(7, 0, 9, 0, 16'h0000, 0);
      chk("jobC_no_writes", n_wr - wa0, 0);
      chk("jobC_no_outs", n_od - od0, 0);

      // Reset in the middle of LOAD after two of four words.
      s0 = n_start; wa0 = n_wr;
      exp_ib = 5; exp_ob = 20;
      expect_job(5, 2, 20, 0, 16'hD000, 1'b0);
      send_cmd(5, 4, 20, 2);
      send_words(2, 16'hD000);
      chk("midjob_in_ready", in_ready, 1);
      chk("midjob_input_base", input_base, 5);
      in_valid = 1'b1;
      in_data  = 16'hD002;
      #1 rst_n = 1'b0;
      #1 zero_check();
      in_valid = 1'b0;
      in_data  = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_cmd_ready", cmd_ready, 1);
      repeat (20) @(posedge clk);
      #1;
      chk("abort_no_start", n_start - s0, 0);
      chk("abort_writes", n_wr - wa0, 2);
      chk("abort_busy", busy, 0);

      // Over-long lengths clamp to the buffer depth.
      wa0 = n_wr; od0 = n_od;
      run_job(0, 33, 5, 40, 16'h5000, 0);
      chk("clamp_writes", n_wr - wa0, 32);
      chk("clamp_outs", n_od - od0, 32);
      chk("clamp_out_first", got_od[od0], 16'h5005);
      chk("clamp_out_last", got_od[od0 + 31], 16'h5004);

`ifdef MHSA_HOST_TIMEOUT_EN
      // Accelerator never answers: watchdog ends the job.
      to_mode = 1'b1;
      accel_en = 1'b0;
      s0 = n_start; d0 = n_done; w0 = n_wait; od0 = n_od;
      exp_ib = 3; exp_ob = 4;
      send_cmd(3, 0, 4, 2);
      wait_done(d0, 500);
      chk("to_wait_cycles", n_wait - w0, TO);
      chk("to_start", n_start - s0, 1);
      chk("to_no_outs", n_od - od0, 0);
      chk("to_err_sticky", err_timeout, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
